pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Central sequencer for the 5-stage pipeline: owns stall/flush of the four pipeline registers
//  (FD, DE, EM, MW) and the fetch redirect. Resolves load-use hazards, latches Execute-stage
//  branch/MRET redirects across memory stalls, and applies trap flushes from commit.
//  Also counts stall cycles and flags a data-memory timeout.
// PARAMETERS
//  MEM_TIMEOUT   256  consecutive memoryBusy cycles before busTimeout pulses (>=2)
//  COUNT_WIDTH   32   width of stallCount (saturating)
// PORTS
//  clock                 in   1   single clock; all state on posedge
//  reset                 in   1   synchronous, active-high
//  branchValid           in   1   Execute gated branch/jump taken (gatedBranchValid)
//  mretSignal            in   1   Execute MRET; redirect to branchTarget (holds MEPC)
//  branchTarget          in   32  Execute branchData
//  trapTaken             in   1   commit-stage trap entry request
//  trapVector            in   32  trap handler address (MTVEC-derived)
//  fetchReady            in   1   IMEM side accepts a redirect this cycle
//  memoryBusy            in   1   DMEM access in Memory stage not complete
//  decodeRs1/decodeRs2   in   5   source registers of instruction in Decode
//  decodeUsesRs1/Rs2     in   1   source register actually read
//  executeRd             in   5   destination of instruction in Execute
//  executeMemRead        in   1   Execute holds a load
//  executeValid          in   1   Execute payload valid
//  fetchDecodeControl    out  control  {stall, flush} for FD register
//  decodeExecuteControl  out  control  for DE register
//  executeMemoryControl  out  control  for EM register
//  memoryWritebackControl out control  for MW register
//  redirectValid         out  1   new PC to fetch
//  redirectPC            out  32  redirect target
//  busTimeout            out  1   one-cycle pulse on DMEM timeout
//  stallCount            out  COUNT_WIDTH  cycles with any stage stalled
// BEHAVIOUR
//  Control semantics: stall=hold register; flush=clear valid (bubble). flush overrides stall.
//  Reset: state RUN, all controls 0, redirectValid 0, redirectPC 0, busTimeout 0,
//   stallCount 0, pending target 0, timeout counter 0. Reset mid-REDIRECT/TRAP drops request.
//  Priority per cycle: trapTaken > memoryBusy > redirect (branchValid|mretSignal or pending)
//   > load-use.
//  Trap: trapTaken -> flush FD,DE,EM,MW; redirectValid=1, redirectPC=trapVector. If !fetchReady,
//   latch trapVector, go TRAP_WAIT; hold FD/DE/EM/MW flush and redirect until fetchReady, then RUN.
//   Trap discards any pending branch redirect.
//  memoryBusy: stall FD,DE,EM; flush MW (bubble to writeback). A redirect seen during the stall
//   is latched (Execute raises it for one cycle only) and issued on the first non-busy cycle.
//  Redirect: (branchValid|mretSignal) or pending -> flush FD and DE, redirectValid=1,
//   redirectPC=target; same cycle if fetchReady else REDIRECT_WAIT holding target/flushes.
//   New redirect while in REDIRECT_WAIT is ignored (Execute is flushed). Pending clears on issue.
//  Load-use: executeValid & executeMemRead & executeRd!=0 & ((usesRs1&rs1==rd)|(usesRs2&rs2==rd))
//   -> stall FD, flush DE, EM advances; exactly one bubble. Suppressed when redirect issues.
//  Timeout: counter increments while memoryBusy, clears when low; at MEM_TIMEOUT-1 -> busTimeout
//   pulses once, counter holds until memoryBusy drops (no repeat pulse).
//  stallCount: +1 any cycle any control.stall=1; saturates at all-ones.
//  All outputs combinational from state+inputs except busTimeout, stallCount (registered).
//  States: RUN -> TRAP_WAIT (trap & !fetchReady) | REDIRECT_WAIT (redirect & !fetchReady);
//   REDIRECT_WAIT -> TRAP_WAIT on trapTaken; either WAIT -> RUN on fetchReady.
// STRUCTURE
//  StaticPack: control typedef (existing), hazardState_ enum {RUN, REDIRECT_WAIT, TRAP_WAIT}.
//  ConfigPack: MEM_TIMEOUT default.
//  Sub-module: stall_watchdog (timeout counter + busTimeout pulse), instantiated once.
// TESTING
//  1 lw x5 in EX, add uses rs1=x5 in DE -> 1 cycle FD.stall=1, DE.flush=1; x0 rd -> no stall.
//  2 branchValid, target 0x0000_0100, fetchReady=1 -> redirectPC=0x100 same cycle, FD/DE flush.
//  3 branchValid during memoryBusy (3 cycles) -> redirect held, issued cycle busy drops, 0x100.
//  4 trapTaken + branchValid same cycle, trapVector 0x0000_0040 -> redirectPC=0x40, all 4 flush.
//  5 trap with fetchReady=0 for 4 cycles -> TRAP_WAIT holds flush+redirect 0x40, RUN on ready.
//  6 memoryBusy held 300 cycles, MEM_TIMEOUT=256 -> single busTimeout at cycle 256; stallCount=300.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and configuration defaults for the pipeline hazard controller.
package pipeline_hazard_controller_pkg;

  // Per-register pipeline control: stall holds the register, flush clears its valid.
  // Packed as {stall, flush}; flush wins when both are set.
  typedef struct packed {
    logic stall;
    logic flush;
  } control_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    RUN           = 2'd0,
    REDIRECT_WAIT = 2'd1,
    TRAP_WAIT     = 2'd2
  } hazard_state_e;

  // Configuration defaults.
  localparam int MEM_TIMEOUT_DEFAULT = 256;
  localparam int COUNT_WIDTH_DEFAULT = 32;

  localparam control_t CTRL_NONE  = '{stall: 1'b0, flush: 1'b0};
  localparam control_t CTRL_STALL = '{stall: 1'b1, flush: 1'b0};
  localparam control_t CTRL_FLUSH = '{stall: 1'b0, flush: 1'b1};

endpackage

// File: rtl/pipeline_hazard_controller_stall_watchdog.sv
// Data-memory watchdog: counts consecutive busy cycles and emits a single
// registered busTimeout pulse once the count reaches MEM_TIMEOUT-1.
module stall_watchdog #(
  parameter int MEM_TIMEOUT = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic memoryBusy,
  output logic busTimeout
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] ARM  = CW'(MEM_TIMEOUT - 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Count busy cycles, park at LAST so the pulse cannot repeat until busy drops.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (!memoryBusy) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d   = cnt_q + 1'b1;
      pulse_d = (cnt_q == ARM);
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign busTimeout = pulse_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central hazard sequencer for the 5-stage pipeline: drives stall/flush of the
// FD/DE/EM/MW registers and the fetch redirect, resolves load-use hazards,
// carries Execute redirects across memory stalls and applies commit traps.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   branchValid,
  input  logic                   mretSignal,
  input  logic [31:0]            branchTarget,
  input  logic                   trapTaken,
  input  logic [31:0]            trapVector,
  input  logic                   fetchReady,
  input  logic                   memoryBusy,
  input  logic [4:0]             decodeRs1,
  input  logic [4:0]             decodeRs2,
  input  logic                   decodeUsesRs1,
  input  logic                   decodeUsesRs2,
  input  logic [4:0]             executeRd,
  input  logic                   executeMemRead,
  input  logic                   executeValid,
  output control_t               fetchDecodeControl,
  output control_t               decodeExecuteControl,
  output control_t               executeMemoryControl,
  output control_t               memoryWritebackControl,
  output logic                   redirectValid,
  output logic [31:0]            redirectPC,
  output logic                   busTimeout,
  output logic [COUNT_WIDTH-1:0] stallCount
);

  // Saturating increment for the stall counter.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  hazard_state_e state_q, state_d;
  logic          pendValid_q, pendValid_d;
  logic [31:0]   pendTarget_q, pendTarget_d;
  logic [31:0]   waitTarget_q, waitTarget_d;
  logic [COUNT_WIDTH-1:0] stallCount_q, stallCount_d;

  logic        execRedirect;
  logic        loadUse;
  logic [31:0] runTarget;
  logic        anyStall;

  assign execRedirect = branchValid | mretSignal;
  assign runTarget    = pendValid_q ? pendTarget_q : branchTarget;

  // Load in Execute feeding a register actually read by Decode; x0 never hazards.
  always_comb begin
    loadUse = executeValid && executeMemRead && (executeRd != 5'd0) &&
              ((decodeUsesRs1 && (decodeRs1 == executeRd)) ||
               (decodeUsesRs2 && (decodeRs2 == executeRd)));
  end

  // Next-state and per-cycle control decode; trap > memoryBusy > redirect > load-use.
  always_comb begin
    state_d                = state_q;
    pendValid_d            = pendValid_q;
    pendTarget_d           = pendTarget_q;
    waitTarget_d           = waitTarget_q;
    fetchDecodeControl     = CTRL_NONE;
    decodeExecuteControl   = CTRL_NONE;
    executeMemoryControl   = CTRL_NONE;
    memoryWritebackControl = CTRL_NONE;
    redirectValid          = 1'b0;
    redirectPC             = '0;

    unique case (state_q)
      RUN: begin
        if (trapTaken) begin
          fetchDecodeControl     = CTRL_FLUSH;
          decodeExecuteControl   = CTRL_FLUSH;
          executeMemoryControl   = CTRL_FLUSH;
          memoryWritebackControl = CTRL_FLUSH;
          redirectValid          = 1'b1;
          redirectPC             = trapVector;
          pendValid_d            = 1'b0;
          if (!fetchReady) begin
            state_d      = TRAP_WAIT;
            waitTarget_d = trapVector;
          end
        end else if (memoryBusy) begin
          fetchDecodeControl     = CTRL_STALL;
          decodeExecuteControl   = CTRL_STALL;
          executeMemoryControl   = CTRL_STALL;
          memoryWritebackControl = CTRL_FLUSH;
          // Execute raises its redirect for one cycle only; keep it for after the stall.
          if (execRedirect && !pendValid_q) begin
            pendValid_d  = 1'b1;
            pendTarget_d = branchTarget;
          end
        end else if (execRedirect || pendValid_q) begin
          fetchDecodeControl   = CTRL_FLUSH;
          decodeExecuteControl = CTRL_FLUSH;
          redirectValid        = 1'b1;
          redirectPC           = runTarget;
          pendValid_d          = 1'b0;
          if (!fetchReady) begin
            state_d      = REDIRECT_WAIT;
            waitTarget_d = runTarget;
          end
        end else if (loadUse) begin
          fetchDecodeControl   = CTRL_STALL;
          decodeExecuteControl = CTRL_FLUSH;
        end
      end

      REDIRECT_WAIT: begin
        if (trapTaken) begin
          fetchDecodeControl     = CTRL_FLUSH;
          decodeExecuteControl   = CTRL_FLUSH;
          executeMemoryControl   = CTRL_FLUSH;
          memoryWritebackControl = CTRL_FLUSH;
          redirectValid          = 1'b1;
          redirectPC             = trapVector;
          pendValid_d            = 1'b0;
          if (fetchReady) begin
            state_d = RUN;
          end else begin
            state_d      = TRAP_WAIT;
            waitTarget_d = trapVector;
          end
        end else begin
          // Execute is flushed while waiting, so any new redirect it shows is stale.
          fetchDecodeControl   = CTRL_FLUSH;
          decodeExecuteControl = CTRL_FLUSH;
          redirectValid        = 1'b1;
          redirectPC           = waitTarget_q;
          if (memoryBusy) begin
            executeMemoryControl   = CTRL_STALL;
            memoryWritebackControl = CTRL_FLUSH;
          end
          if (fetchReady) begin
            state_d = RUN;
          end
        end
      end

      TRAP_WAIT: begin
        fetchDecodeControl     = CTRL_FLUSH;
        decodeExecuteControl   = CTRL_FLUSH;
        executeMemoryControl   = CTRL_FLUSH;
        memoryWritebackControl = CTRL_FLUSH;
        redirectValid          = 1'b1;
        redirectPC             = waitTarget_q;
        if (fetchReady) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Any stage held this cycle counts toward the stall statistic.
  always_comb begin
    anyStall     = fetchDecodeControl.stall | decodeExecuteControl.stall |
                   executeMemoryControl.stall | memoryWritebackControl.stall;
    stallCount_d = anyStall ? sat_inc(stallCount_q) : stallCount_q;
  end

  // Sequencer state, latched redirect targets and stall counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      pendValid_q  <= 1'b0;
      pendTarget_q <= '0;
      waitTarget_q <= '0;
      stallCount_q <= '0;
    end else begin
      state_q      <= state_d;
      pendValid_q  <= pendValid_d;
      pendTarget_q <= pendTarget_d;
      waitTarget_q <= waitTarget_d;
      stallCount_q <= stallCount_d;
    end
  end

  assign stallCount = stallCount_q;

  stall_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_stall_watchdog (
    .clock      (clock),
    .reset      (reset),
    .memoryBusy (memoryBusy),
    .busTimeout (busTimeout)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller.
module tb_pipeline_hazard_controller;
  import pipeline_hazard_controller_pkg::*;

  localparam int MEM_TIMEOUT = 256;
  localparam int COUNT_WIDTH = 32;

  localparam logic [1:0] NON = 2'b00;
  localparam logic [1:0] STL = 2'b10;
  localparam logic [1:0] FLS = 2'b01;

  logic        clock = 1'b0;
  logic        reset;
  logic        branchValid, mretSignal, trapTaken, fetchReady, memoryBusy;
  logic [31:0] branchTarget, trapVector;
  logic [4:0]  decodeRs1, decodeRs2, executeRd;
  logic        decodeUsesRs1, decodeUsesRs2, executeMemRead, executeValid;
  control_t    fetchDecodeControl, decodeExecuteControl;
  control_t    executeMemoryControl, memoryWritebackControl;
  logic        redirectValid;
  logic [31:0] redirectPC;
  logic        busTimeout;
  logic [COUNT_WIDTH-1:0] stallCount;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses;
  int pulse_at;

  always #5 clock = ~clock;

  pipeline_hazard_controller #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .branchValid            (branchValid),
    .mretSignal             (mretSignal),
    .branchTarget           (branchTarget),
    .trapTaken              (trapTaken),
    .trapVector             (trapVector),
    .fetchReady             (fetchReady),
    .memoryBusy             (memoryBusy),
    .decodeRs1              (decodeRs1),
    .decodeRs2              (decodeRs2),
    .decodeUsesRs1          (decodeUsesRs1),
    .decodeUsesRs2          (decodeUsesRs2),
    .executeRd              (executeRd),
    .executeMemRead         (executeMemRead),
    .executeValid           (executeValid),
    .fetchDecodeControl     (fetchDecodeControl),
    .decodeExecuteControl   (decodeExecuteControl),
    .executeMemoryControl   (executeMemoryControl),
    .memoryWritebackControl (memoryWritebackControl),
    .redirectValid          (redirectValid),
    .redirectPC             (redirectPC),
    .busTimeout             (busTimeout),
    .stallCount             (stallCount)
  );

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected controls packed {FD, DE, EM, MW}, each {stall, flush}.
  task automatic check_ctrl(input string tag, input logic [7:0] exp);
    expect_eq(tag, {24'h0, fetchDecodeControl, decodeExecuteControl,
                    executeMemoryControl, memoryWritebackControl}, {24'h0, exp});
  endtask

  task automatic check_redir(input string tag, input logic v, input logic [31:0] pc);
    expect_eq({tag, "_rv"}, {31'h0, redirectValid}, {31'h0, v});
    if (v) expect_eq({tag, "_pc"}, redirectPC, pc);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    branchValid = 0; mretSignal = 0; branchTarget = '0;
    trapTaken = 0; trapVector = '0; fetchReady = 1; memoryBusy = 0;
    decodeRs1 = '0; decodeRs2 = '0; decodeUsesRs1 = 0; decodeUsesRs2 = 0;
    executeRd = '0; executeMemRead = 0; executeValid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_bound: got running expected finished");
    $fatal(1, "simulation time bound exceeded");
  end

  initial begin
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check_ctrl("rst_ctrl", 8'h00);
    check_redir("rst", 1'b0, 32'h0);
    expect_eq("rst_tmo", {31'h0, busTimeout}, 32'h0);
    expect_eq("rst_cnt", stallCount, 32'h0);
    step();
    reset = 0;

    // Load-use hazards
    executeValid = 1; executeMemRead = 1; executeRd = 5'd5;
    decodeRs1 = 5'd5; decodeUsesRs1 = 1;
    @(negedge clock); check_ctrl("lu_rs1", {STL, FLS, NON, NON});
    step(); executeValid = 0;
    @(negedge clock); check_ctrl("lu_bubble", 8'h00);
    step(); executeValid = 1; executeRd = 5'd0; decodeRs1 = 5'd0;
    @(negedge clock); check_ctrl("lu_x0", 8'h00);
    step(); executeRd = 5'd7; decodeRs1 = 5'd7; decodeUsesRs1 = 0;
    decodeRs2 = 5'd9; decodeUsesRs2 = 1;
    @(negedge clock); check_ctrl("lu_unused", 8'h00);
    step(); decodeRs2 = 5'd7;
    @(negedge clock); check_ctrl("lu_rs2", {STL, FLS, NON, NON});
    step(); executeMemRead = 0;
    @(negedge clock); check_ctrl("lu_noload", 8'h00);
    expect_eq("lu_cnt", stallCount, 32'd2);

    // Branch redirect, overriding a simultaneous load-use
    step(); idle_inputs();
    branchValid = 1; branchTarget = 32'h0000_0100;
    executeValid = 1; executeMemRead = 1; executeRd = 5'd5;
    decodeRs1 = 5'd5; decodeUsesRs1 = 1;
    @(negedge clock); check_redir("br", 1'b1, 32'h100);
    check_ctrl("br_ctrl", {FLS, FLS, NON, NON});
    step(); idle_inputs(); mretSignal = 1; branchTarget = 32'h8000_0010;
    @(negedge clock); check_redir("mret", 1'b1, 32'h8000_0010);
    step(); idle_inputs();
    @(negedge clock); check_redir("br_after", 1'b0, 32'h0);

    // Redirect raised during a memory stall
    step(); memoryBusy = 1; branchValid = 1; branchTarget = 32'h0000_0100;
    @(negedge clock); check_ctrl("busy1", {STL, STL, STL, FLS});
    check_redir("busy1", 1'b0, 32'h0);
    step(); branchValid = 0; branchTarget = 32'hDEAD_BEEF;
    @(negedge clock); check_redir("busy2", 1'b0, 32'h0);
    step();
    @(negedge clock); check_ctrl("busy3", {STL, STL, STL, FLS});
    step(); memoryBusy = 0;
    @(negedge clock); check_redir("busy_rel", 1'b1, 32'h100);
    check_ctrl("busy_rel_ctrl", {FLS, FLS, NON, NON});
    step();
    @(negedge clock); check_redir("busy_done", 1'b0, 32'h0);

    // Trap beats a same-cycle branch
    step(); idle_inputs();
    trapTaken = 1; trapVector = 32'h0000_0040; branchValid = 1; branchTarget = 32'h100;
    @(negedge clock); check_redir("trap_br", 1'b1, 32'h40);
    check_ctrl("trap_br_ctrl", {FLS, FLS, FLS, FLS});
    step(); idle_inputs();
    @(negedge clock); check_redir("trap_after", 1'b0, 32'h0);

    // Trap discards a redirect latched during a stall
    step(); memoryBusy = 1; branchValid = 1; branchTarget = 32'h300;
    step(); memoryBusy = 0; branchValid = 0; trapTaken = 1; trapVector = 32'h40;
    @(negedge clock); check_redir("trap_pend", 1'b1, 32'h40);
    step(); trapTaken = 0;
    @(negedge clock); check_redir("trap_nopend", 1'b0, 32'h0);

    // Trap with fetch not ready for four cycles
    step(); idle_inputs(); trapTaken = 1; trapVector = 32'h40; fetchReady = 0;
    @(negedge clock); check_redir("tw1", 1'b1, 32'h40);
    check_ctrl("tw1_ctrl", {FLS, FLS, FLS, FLS});
    step(); trapTaken = 0; trapVector = 32'h999;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); check_redir("tw_hold", 1'b1, 32'h40);
      check_ctrl("tw_hold_ctrl", {FLS, FLS, FLS, FLS});
      step();
    end
    fetchReady = 1;
    @(negedge clock); check_redir("tw_ready", 1'b1, 32'h40);
    step();
    @(negedge clock); check_redir("tw_run", 1'b0, 32'h0);
    check_ctrl("tw_run_ctrl", 8'h00);

    // Redirect waiting for fetch; later redirect ignored
    step(); idle_inputs(); branchValid = 1; branchTarget = 32'h100; fetchReady = 0;
    @(negedge clock); check_redir("rw1", 1'b1, 32'h100);
    step(); branchTarget = 32'h500;
    @(negedge clock); check_redir("rw_ignore", 1'b1, 32'h100);
    check_ctrl("rw_ctrl", {FLS, FLS, NON, NON});
    step(); branchValid = 0; fetchReady = 1;
    @(negedge clock); check_redir("rw_ready", 1'b1, 32'h100);
    step();
    @(negedge clock); check_redir("rw_run", 1'b0, 32'h0);

    // Redirect wait promoted to trap wait
    step(); branchValid = 1; branchTarget = 32'h100; fetchReady = 0;
    step(); branchValid = 0; trapTaken = 1; trapVector = 32'h40;
    @(negedge clock); check_redir("rt_trap", 1'b1, 32'h40);
    check_ctrl("rt_ctrl", {FLS, FLS, FLS, FLS});
    step(); trapTaken = 0; trapVector = 32'h0;
    @(negedge clock); check_redir("rt_hold", 1'b1, 32'h40);
    step(); fetchReady = 1;
    @(negedge clock); check_redir("rt_ready", 1'b1, 32'h40);
    step();
    @(negedge clock); check_redir("rt_run", 1'b0, 32'h0);

    // Data-memory timeout over a 300-cycle busy period
    step(); idle_inputs(); reset = 1;
    step(); reset = 0; memoryBusy = 1;
    pulses = 0; pulse_at = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clock);
      if (busTimeout) begin
        pulses++;
        pulse_at = i;
      end
      step();
    end
    memoryBusy = 0;
    @(negedge clock);
    expect_eq("tmo_pulses", pulses, 32'd1);
    expect_eq("tmo_cycle", pulse_at, 32'd256);
    expect_eq("tmo_cnt", stallCount, 32'd300);
    expect_eq("tmo_clear", {31'h0, busTimeout}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
